// File: rtl/systolic_pkg.sv
// Shared types and constants for the weight-stationary systolic array sequencer.
package systolic_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_W_FETCH,
    ST_LOAD_W,
    ST_X_FETCH,
    ST_COMPUTE,
    ST_DRAIN,
    ST_DONE
  } state_t;

  localparam logic [1:0] MODE_IDLE = 2'b00;
  localparam logic [1:0] MODE_LOAD = 2'b01;
  localparam logic [1:0] MODE_COMP = 2'b10;

  // Cycles needed after the last vector enters until the final column result exits.
  function automatic int drain_len(input int rows, input int cols);
    return rows + cols - 1;
  endfunction

endpackage

// File: rtl/systolic_array_ctrl_colvalid.sv
// Per-column result-valid window: column c is final for num_vec cycles starting at t=ROWS+c.
module ctrl_colvalid_gen
  import systolic_pkg::*;
#(
  parameter int ROWS  = 8,
  parameter int COLS  = 8,
  parameter int VEC_W = 10
) (
  input  logic [VEC_W:0]   t,
  input  logic [VEC_W-1:0] num_vec,
  input  logic             active,
  output logic [COLS-1:0]  out_valid
);

  logic [VEC_W:0] lo;

  always_comb begin
    out_valid = '0;
    lo        = '0;
    for (int c = 0; c < COLS; c++) begin
      lo = (VEC_W + 1)'(ROWS + c);
      // Upper bound written as strict less-than so num_vec=0 cannot underflow.
      out_valid[c] = active && (t >= lo) && (t < lo + {1'b0, num_vec});
    end
  end

endmodule

// File: rtl/systolic_array_ctrl.sv
// Sequencer for the weight-stationary systolic array: weight load, vector streaming, drain.
//   state      | meaning
//   ST_IDLE    | waiting for start
//   ST_W_FETCH | first weight read (bottom row) issued
//   ST_LOAD_W  | weights shift down the PE rows, one row per cycle
//   ST_X_FETCH | first activation read issued
//   ST_COMPUTE | vectors streamed into the array
//   ST_DRAIN   | partial sums flushed out of the array
//   ST_DONE    | one-cycle done pulse
module systolic_array_ctrl
  import systolic_pkg::*;
#(
  parameter int ROWS   = 8,
  parameter int COLS   = 8,
  parameter int VEC_W  = 10,
  parameter int ROW_AW = $clog2(ROWS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [VEC_W-1:0]  num_vec,
  input  logic              reuse_w,
  input  logic              stall,
  output logic              busy,
  output logic              done,
  output logic [1:0]        mode_ctrl,
  output logic              w_rd_en,
  output logic [ROW_AW-1:0] w_rd_addr,
  output logic              weight_ready_in,
  output logic              x_rd_en,
  output logic [VEC_W-1:0]  x_rd_addr,
  output logic              x_valid,
  output logic [COLS-1:0]   out_valid
);

  localparam int TW = VEC_W + 1;
  localparam logic [TW-1:0]     ONE        = TW'(1);
  localparam logic [TW-1:0]     DRAIN_OFF  = TW'(drain_len(ROWS, COLS) - 1);
  localparam logic [ROW_AW-1:0] LAST_ROW   = ROW_AW'(ROWS - 1);

  state_t             state;
  logic [VEC_W-1:0]   num_vec_q;
  logic [ROW_AW-1:0]  w_idx;
  logic [TW-1:0]      t;
  logic               weights_loaded;

  logic [TW-1:0] nv_ext;
  logic [TW-1:0] t_next;
  logic          active;

  assign nv_ext = {1'b0, num_vec_q};
  assign t_next = t + ONE;
  assign active = ((state == ST_COMPUTE) || (state == ST_DRAIN)) && !stall;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= ST_IDLE;
      num_vec_q      <= '0;
      w_idx          <= '0;
      t              <= '0;
      weights_loaded <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          t <= '0;
          if (start) begin
            num_vec_q <= num_vec;
            state     <= (reuse_w && weights_loaded) ? ST_X_FETCH : ST_W_FETCH;
          end
        end
        ST_W_FETCH: begin
          w_idx <= '0;
          state <= ST_LOAD_W;
        end
        ST_LOAD_W: begin
          if (w_idx == LAST_ROW) begin
            weights_loaded <= 1'b1;
            state          <= (num_vec_q == '0) ? ST_DONE : ST_X_FETCH;
          end else begin
            w_idx <= w_idx + 1'b1;
          end
        end
        ST_X_FETCH: begin
          t     <= '0;
          state <= (num_vec_q == '0) ? ST_DONE : ST_COMPUTE;
        end
        ST_COMPUTE: begin
          if (!stall) begin
            t <= t_next;
            if (t == nv_ext - ONE) state <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          if (!stall) begin
            t <= t_next;
            if (t == nv_ext + DRAIN_OFF) state <= ST_DONE;
          end
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  always_comb begin
    busy            = (state != ST_IDLE);
    done            = (state == ST_DONE);
    weight_ready_in = (state == ST_LOAD_W);
    mode_ctrl       = MODE_IDLE;
    if (state == ST_LOAD_W) mode_ctrl = MODE_LOAD;
    else if (active)        mode_ctrl = MODE_COMP;

    w_rd_en   = 1'b0;
    w_rd_addr = '0;
    if (state == ST_W_FETCH) begin
      w_rd_en   = 1'b1;
      w_rd_addr = LAST_ROW;
    end else if (state == ST_LOAD_W && w_idx != LAST_ROW) begin
      // Rows are fetched bottom-up so the first row loaded shifts furthest down.
      w_rd_en   = 1'b1;
      w_rd_addr = ROW_AW'(ROWS - 2) - w_idx;
    end

    x_rd_en   = 1'b0;
    x_rd_addr = '0;
    x_valid   = 1'b0;
    if (state == ST_X_FETCH) begin
      x_rd_en = 1'b1;
    end else if (state == ST_COMPUTE) begin
      x_rd_addr = VEC_W'(t_next);
      x_rd_en   = !stall && (t_next < nv_ext);
      x_valid   = !stall;
    end
  end

  ctrl_colvalid_gen #(
    .ROWS  (ROWS),
    .COLS  (COLS),
    .VEC_W (VEC_W)
  ) u_colvalid (
    .t         (t),
    .num_vec   (num_vec_q),
    .active    (active),
    .out_valid (out_valid)
  );

endmodule

// File: tb/tb_systolic_array_ctrl.sv
// Scoreboard bench for systolic_array_ctrl with a 4x4 array.
module tb_systolic_array_ctrl;

  localparam int ROWS   = 4;
  localparam int COLS   = 4;
  localparam int VEC_W  = 10;
  localparam int ROW_AW = 2;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              start = 1'b0;
  logic [VEC_W-1:0]  num_vec = '0;
  logic              reuse_w = 1'b0;
  logic              stall = 1'b0;
  logic              busy, done, w_rd_en, weight_ready_in, x_rd_en, x_valid;
  logic [1:0]        mode_ctrl;
  logic [ROW_AW-1:0] w_rd_addr;
  logic [VEC_W-1:0]  x_rd_addr;
  logic [COLS-1:0]   out_valid;

  systolic_array_ctrl #(.ROWS(ROWS), .COLS(COLS), .VEC_W(VEC_W), .ROW_AW(ROW_AW)) dut (
    .clk(clk), .rst(rst), .start(start), .num_vec(num_vec), .reuse_w(reuse_w),
    .stall(stall), .busy(busy), .done(done), .mode_ctrl(mode_ctrl),
    .w_rd_en(w_rd_en), .w_rd_addr(w_rd_addr), .weight_ready_in(weight_ready_in),
    .x_rd_en(x_rd_en), .x_rd_addr(x_rd_addr), .x_valid(x_valid), .out_valid(out_valid)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit               start;
    bit               reuse;
    bit               stall;
    logic [VEC_W-1:0] nv;
    logic             busy;
    logic             done;
    logic [1:0]       mode;
    logic             w_en;
    logic [ROW_AW-1:0] w_addr;
    logic             wri;
    logic             x_en;
    logic [VEC_W-1:0] x_addr;
    logic             x_valid;
    logic [COLS-1:0]  ov;
  } vec_t;

  vec_t sb[$];
  int vectors = 0;
  int miscompares = 0;

  function automatic vec_t blank(input int nv, input bit reuse);
    vec_t v;
    v.start = 0; v.reuse = reuse; v.stall = 0; v.nv = VEC_W'(nv);
    v.busy = 0; v.done = 0; v.mode = 2'b00; v.w_en = 0; v.w_addr = '0; v.wri = 0;
    v.x_en = 0; v.x_addr = '0; v.x_valid = 0; v.ov = '0;
    return v;
  endfunction

  // Expected timeline of one job, cycle 0 being the IDLE cycle carrying start.
  task automatic push_job(input int nv, input bit reuse, input bit load,
                          input int st_lo, input int st_hi, input bit start_busy);
    vec_t v;
    int k, t, total;
    k = 0;
    v = blank(nv, reuse); v.start = 1; sb.push_back(v); k++;
    if (load) begin
      v = blank(nv, reuse); v.start = start_busy; v.busy = 1; v.w_en = 1;
      v.w_addr = ROW_AW'(ROWS - 1); sb.push_back(v); k++;
      for (int i = 0; i < ROWS; i++) begin
        v = blank(nv, reuse); v.start = start_busy; v.busy = 1; v.mode = 2'b01; v.wri = 1;
        v.w_en = (i < ROWS - 1); v.w_addr = ROW_AW'(ROWS - 2 - i);
        sb.push_back(v); k++;
      end
    end
    if (nv > 0) begin
      v = blank(nv, reuse); v.start = start_busy; v.busy = 1; v.x_en = 1; v.x_addr = '0;
      sb.push_back(v); k++;
      t = 0;
      total = nv + ROWS + COLS - 1;
      while (t < total) begin
        v = blank(nv, reuse); v.start = start_busy; v.busy = 1;
        if (k >= st_lo && k <= st_hi) begin
          v.stall = 1;
        end else begin
          v.mode = 2'b10;
          v.x_valid = (t < nv);
          v.x_en = (t + 1 < nv);
          v.x_addr = VEC_W'(t + 1);
          for (int c = 0; c < COLS; c++)
            v.ov[c] = (t >= ROWS + c) && (t <= ROWS + c + nv - 1);
          t++;
        end
        sb.push_back(v); k++;
      end
    end
    v = blank(nv, reuse); v.start = start_busy; v.busy = 1; v.done = 1; sb.push_back(v);
    v = blank(nv, reuse); sb.push_back(v);
  endtask

  task automatic run_sb(input string name, input int max_cycles);
    vec_t e;
    int cyc;
    cyc = 0;
    while (sb.size() > 0 && cyc < max_cycles) begin
      @(negedge clk);
      e = sb.pop_front();
      start = e.start; reuse_w = e.reuse; stall = e.stall; num_vec = e.nv;
      #1;
      vectors++;
      if (busy !== e.busy || done !== e.done || mode_ctrl !== e.mode || w_rd_en !== e.w_en ||
          (e.w_en && w_rd_addr !== e.w_addr) || weight_ready_in !== e.wri ||
          x_rd_en !== e.x_en || (e.x_en && x_rd_addr !== e.x_addr) ||
          x_valid !== e.x_valid || out_valid !== e.ov) begin
        miscompares++;
        $display("FAIL %s cycle %0d: got busy=%b done=%b mode=%b wen=%b wa=%0d wri=%b xen=%b xa=%0d xv=%b ov=%b, exp busy=%b done=%b mode=%b wen=%b wa=%0d wri=%b xen=%b xa=%0d xv=%b ov=%b",
                 name, cyc, busy, done, mode_ctrl, w_rd_en, w_rd_addr, weight_ready_in, x_rd_en,
                 x_rd_addr, x_valid, out_valid, e.busy, e.done, e.mode, e.w_en, e.w_addr, e.wri,
                 e.x_en, e.x_addr, e.x_valid, e.ov);
      end
      cyc++;
    end
    sb.delete();
    start = 0; stall = 0;
  endtask

  task automatic check_idle_zero(input string name);
    vectors++;
    if ({busy, done, mode_ctrl, w_rd_en, w_rd_addr, weight_ready_in, x_rd_en, x_rd_addr,
         x_valid, out_valid} !== '0) begin
      miscompares++;
      $display("FAIL %s: got busy=%b done=%b mode=%b wen=%b xen=%b xv=%b ov=%b, exp all zero",
               name, busy, done, mode_ctrl, w_rd_en, x_rd_en, x_valid, out_valid);
    end
  endtask

  task automatic test_reset();
    rst = 1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1 check_idle_zero("reset_state");
    rst = 0;
  endtask

  task automatic test_reuse_after_reset();
    push_job(3, 1, 1, -1, -1, 0);
    run_sb("reuse_after_reset", 100);
  endtask

  task automatic test_full_load();
    push_job(3, 0, 1, -1, -1, 0);
    run_sb("full_load", 100);
  endtask

  task automatic test_back_to_back_reuse();
    // start held high throughout: busy-time and DONE-cycle starts must be ignored.
    push_job(3, 1, 0, -1, -1, 1);
    run_sb("reuse_start_held", 100);
  endtask

  task automatic test_stall();
    push_job(3, 0, 1, 12, 13, 0);
    run_sb("stall", 100);
  endtask

  task automatic test_zero_vec();
    push_job(0, 0, 1, -1, -1, 0);
    run_sb("zero_vec", 100);
  endtask

  task automatic test_mid_reset();
    push_job(3, 0, 1, -1, -1, 0);
    run_sb("mid_reset_pre", 9);
    @(negedge clk);
    rst = 1;
    #1 check_idle_zero("mid_reset_assert");
    @(negedge clk);
    rst = 0;
    #1 check_idle_zero("mid_reset_release");
    push_job(3, 1, 1, -1, -1, 0);
    run_sb("reuse_after_mid_reset", 100);
  endtask

  initial begin
    test_reset();
    test_reuse_after_reset();
    test_full_load();
    test_back_to_back_reuse();
    test_stall();
    test_zero_vec();
    test_mid_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got no completion, exp bench end");
    $fatal(1, "timeout");
  end

endmodule
